// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C register sequencer: FSM states, status codes,
// R/W bit values and the byte-controller command word.
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR_W   = 3'd1,
    REG      = 3'd2,
    WDATA    = 3'd3,
    ADDR_R   = 3'd4,
    RDATA    = 3'd5,
    ERR_STOP = 3'd6
  } seq_state_e;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_NACK = 2'd1;
  localparam logic [1:0] ST_AL   = 2'd2;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       read;
    logic       write;
    logic       ack_in;
    logic [7:0] din;
  } bc_cmd_t;

  localparam bc_cmd_t CMD_NONE = '0;

  function automatic bc_cmd_t mk_cmd(input logic start, input logic stop,
                                     input logic read, input logic write,
                                     input logic ack_in, input logic [7:0] din);
    bc_cmd_t c;
    c.start  = start;
    c.stop   = stop;
    c.read   = read;
    c.write  = write;
    c.ack_in = ack_in;
    c.din    = din;
    return c;
  endfunction

  localparam bc_cmd_t CMD_STOP = '{start: 1'b0, stop: 1'b1, read: 1'b0,
                                   write: 1'b0, ack_in: 1'b0, din: 8'h00};

endpackage

// File: rtl/i2c_reg_seq.sv
// Register-access sequencer driving an I2C byte controller, one command per state.
// Build option I2C_SEQ_RETRY_EN: retry the transfer after an address NACK, up to RETRIES times.
module i2c_reg_seq
  import i2c_seq_pkg::*;
#(
  parameter int RETRIES = 2,
  localparam int RCW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1
) (
  input  logic           clk,
  input  logic           nReset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_rnw,
  input  logic [6:0]     req_dev,
  input  logic [7:0]     req_reg,
  input  logic [7:0]     req_wdata,
  output logic           done,
  output logic [1:0]     status,
  output logic [7:0]     rdata,
  output logic           bc_start,
  output logic           bc_stop,
  output logic           bc_read,
  output logic           bc_write,
  output logic           bc_ack_in,
  output logic [7:0]     bc_din,
  input  logic           bc_cmd_ack,
  input  logic           bc_ack_out,
  input  logic [7:0]     bc_dout,
  input  logic           bc_al,
  output logic [2:0]     dbg_state,
  output logic [RCW-1:0] dbg_retry
);

  // Handshakes: a request transfers on req_valid & req_ready (ready only in IDLE).
  // A command word is held until bc_cmd_ack; on that cycle bc_ack_out/bc_dout are
  // sampled and the next word (or none) is registered for the following cycle.
  seq_state_e state_q, state_d;
  bc_cmd_t    cmd_q, cmd_d;
  logic       done_q, done_d;
  logic [1:0] status_q, status_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rnw_q, rnw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wdata_q, wdata_d;

`ifdef I2C_SEQ_RETRY_EN
  logic [RCW-1:0] retry_q, retry_d;
  logic           retry_pend_q, retry_pend_d;
  logic           can_retry;
  assign can_retry = (int'(retry_q) < RETRIES);
  assign dbg_retry = retry_q;
`else
  assign dbg_retry = '0;
`endif

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    done_d   = 1'b0;
    status_d = status_q;
    rdata_d  = rdata_q;
    rnw_d    = rnw_q;
    dev_d    = dev_q;
    reg_d    = reg_q;
    wdata_d  = wdata_q;
`ifdef I2C_SEQ_RETRY_EN
    retry_d      = retry_q;
    retry_pend_d = retry_pend_q;
`endif
    // Arbitration loss wins over any cmd_ack seen in the same cycle.
    if (state_q != IDLE && bc_al) begin
      state_d  = IDLE;
      cmd_d    = CMD_NONE;
      done_d   = 1'b1;
      status_d = ST_AL;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            rnw_d   = req_rnw;
            dev_d   = req_dev;
            reg_d   = req_reg;
            wdata_d = req_wdata;
            state_d = ADDR_W;
            cmd_d   = mk_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {req_dev, RW_WRITE});
`ifdef I2C_SEQ_RETRY_EN
            retry_d      = '0;
            retry_pend_d = 1'b0;
`endif
          end
        end
        ADDR_W: begin
          if (bc_cmd_ack) begin
            if (bc_ack_out) begin
              state_d = ERR_STOP;
              cmd_d   = CMD_STOP;
`ifdef I2C_SEQ_RETRY_EN
              retry_pend_d = can_retry;
`endif
            end else begin
              state_d = REG;
              cmd_d   = mk_cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, reg_q);
            end
          end
        end
        REG: begin
          if (bc_cmd_ack) begin
            if (bc_ack_out) begin
              state_d = ERR_STOP;
              cmd_d   = CMD_STOP;
`ifdef I2C_SEQ_RETRY_EN
              retry_pend_d = 1'b0;
`endif
            end else if (rnw_q) begin
              state_d = ADDR_R;
              cmd_d   = mk_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {dev_q, RW_READ});
            end else begin
              state_d = WDATA;
              cmd_d   = mk_cmd(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, wdata_q);
            end
          end
        end
        WDATA: begin
          // Stop already went out with the data byte, so a NACK just reports.
          if (bc_cmd_ack) begin
            state_d  = IDLE;
            cmd_d    = CMD_NONE;
            done_d   = 1'b1;
            status_d = bc_ack_out ? ST_NACK : ST_OK;
          end
        end
        ADDR_R: begin
          if (bc_cmd_ack) begin
            if (bc_ack_out) begin
              state_d = ERR_STOP;
              cmd_d   = CMD_STOP;
`ifdef I2C_SEQ_RETRY_EN
              retry_pend_d = can_retry;
`endif
            end else begin
              state_d = RDATA;
              cmd_d   = mk_cmd(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
            end
          end
        end
        RDATA: begin
          if (bc_cmd_ack) begin
            state_d  = IDLE;
            cmd_d    = CMD_NONE;
            done_d   = 1'b1;
            status_d = ST_OK;
            rdata_d  = bc_dout;
          end
        end
        ERR_STOP: begin
          if (bc_cmd_ack) begin
`ifdef I2C_SEQ_RETRY_EN
            if (retry_pend_q) begin
              state_d      = ADDR_W;
              cmd_d        = mk_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {dev_q, RW_WRITE});
              retry_d      = retry_q + RCW'(1);
              retry_pend_d = 1'b0;
            end else begin
              state_d  = IDLE;
              cmd_d    = CMD_NONE;
              done_d   = 1'b1;
              status_d = ST_NACK;
            end
`else
            state_d  = IDLE;
            cmd_d    = CMD_NONE;
            done_d   = 1'b1;
            status_d = ST_NACK;
`endif
          end
        end
        default: begin
          state_d = IDLE;
          cmd_d   = CMD_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      cmd_q    <= CMD_NONE;
      done_q   <= 1'b0;
      status_q <= ST_OK;
      rdata_q  <= 8'h00;
      rnw_q    <= 1'b0;
      dev_q    <= 7'h00;
      reg_q    <= 8'h00;
      wdata_q  <= 8'h00;
`ifdef I2C_SEQ_RETRY_EN
      retry_q      <= '0;
      retry_pend_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      done_q   <= done_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      rnw_q    <= rnw_d;
      dev_q    <= dev_d;
      reg_q    <= reg_d;
      wdata_q  <= wdata_d;
`ifdef I2C_SEQ_RETRY_EN
      retry_q      <= retry_d;
      retry_pend_q <= retry_pend_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE);
  assign done      = done_q;
  assign status    = status_q;
  assign rdata     = rdata_q;
  assign bc_start  = cmd_q.start;
  assign bc_stop   = cmd_q.stop;
  assign bc_read   = cmd_q.read;
  assign bc_write  = cmd_q.write;
  assign bc_ack_in = cmd_q.ack_in;
  assign bc_din    = cmd_q.din;
  assign dbg_state = state_q;

endmodule

// File: doc/i2c_reg_seq.md
Name: i2c_reg_seq

Overview:
- Transaction sequencer that sits between a simple register-access requester and the I2C byte controller.
- Converts one request into the full I2C command sequence, driving the byte controller's start/stop/read/write/ack_in/din and consuming cmd_ack/ack_out/dout/i2c_al.
- Write sequence: START, device-address+W, register address, data, STOP.
- Read sequence: START, device-address+W, register address, repeated START, device-address+R, one data byte with master NACK, STOP.

Parameters:
- RETRIES, 2, number of extra attempts after an address NACK (used only with I2C_SEQ_RETRY_EN).

Ports:
- clk  in  1  master clock
- nReset  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted on req_valid&req_ready
- req_rnw  in  1  1=read, 0=write
- req_dev  in  7  7-bit device address
- req_reg  in  8  register address
- req_wdata  in  8  write data
- done  out  1  one-cycle completion pulse
- status  out  2  valid with done: 0=OK, 1=NACK, 2=ARB_LOST
- rdata  out  8  read byte; updated only on a successful read
- bc_start  out  1  to byte controller
- bc_stop  out  1  to byte controller
- bc_read  out  1  to byte controller
- bc_write  out  1  to byte controller
- bc_ack_in  out  1  to byte controller
- bc_din  out  8  to byte controller
- bc_cmd_ack  in  1  from byte controller
- bc_ack_out  in  1  from byte controller
- bc_dout  in  8  from byte controller
- bc_al  in  1  from byte controller

Behaviour:
- Reset values: all bc_* outputs 0, done 0, status 0, rdata 0, state IDLE, so req_ready is 1.
- Request capture:
  - All request fields are captured on acceptance.
  - Inputs are ignored while busy.
- Command handshake:
  - Each bc_* command word is registered and held stable until bc_cmd_ack is seen high.
  - On the cmd_ack edge the next command word is loaded, or all commands are cleared, so no command is ever presented while cmd_ack is high.
  - bc_ack_out is sampled on the same cycle as bc_cmd_ack.
- State machine (one byte-controller command per state):
  - IDLE: on accept go to ADDR_W with start=1, write=1, din={dev,0}. The command appears the cycle after accept.
  - ADDR_W: on cmd_ack, if ack_out=1 go to ERR_STOP; else go to REG with write=1, din=reg.
  - REG: on cmd_ack, if ack_out=1 go to ERR_STOP.
    - Write request: go to WDATA with write=1, stop=1, din=wdata.
    - Read request: go to ADDR_R with start=1, write=1, din={dev,1}.
  - WDATA: on cmd_ack go to IDLE, pulse done. Status is NACK if ack_out=1, else OK. Stop has already been issued, so no ERR_STOP.
  - ADDR_R: on cmd_ack, if ack_out=1 go to ERR_STOP; else go to RDATA with read=1, ack_in=1, stop=1.
  - RDATA: on cmd_ack, rdata<=bc_dout, go to IDLE, pulse done with status OK.
  - ERR_STOP: issue stop=1 only; on cmd_ack go to IDLE, pulse done with status NACK.
- Arbitration loss: bc_al high in any non-IDLE state forces IDLE next cycle, clears all bc_* outputs, and pulses done with status ARB_LOST. bc_al takes priority over a simultaneous cmd_ack.
- Timing:
  - req_ready rises in the same cycle as done, so back-to-back requests are legal.
  - Minimum accept-to-done latency is (commands issued) + byte-controller time. The sequencer itself adds 1 cycle per command boundary.
- Reset mid-transaction: outputs return to reset values immediately (asynchronous). The bus is left as the byte controller leaves it.

Optional Feature:
- Macro: I2C_SEQ_RETRY_EN.
- Defined:
  - A NACK in ADDR_W or ADDR_R goes to ERR_STOP, then restarts at ADDR_W. done is not pulsed.
  - This repeats up to RETRIES times, counted by a retry counter cleared on accept.
  - Once retries are exhausted, done pulses with status NACK.
  - REG/WDATA NACKs are never retried.
- Undefined: no retry counter; every NACK terminates on the first occurrence, exactly as specified above.

Decomposition:
- Package i2c_seq_pkg holds:
  - the state enum (IDLE, ADDR_W, REG, WDATA, ADDR_R, RDATA, ERR_STOP);
  - the status codes ST_OK=0, ST_NACK=1, ST_AL=2;
  - the R/W bit constants.
- No sub-module: a single FSM plus capture registers.

Test Plan:
- Write dev=0x50, reg=0x10, data=0xA5, slave model ACKs all:
  - byte controller sees din 0xA0 (start), 0x10, 0xA5 (stop);
  - done with status 0;
  - req_ready returns high.
- Read dev=0x50, reg=0x22, slave returns 0x3C:
  - din sequence 0xA0 (start), 0x22, 0xA1 (start);
  - then read with ack_in=1 and stop;
  - done, status 0, rdata=0x3C.
- Address NACK on 0xA0 (ack_out=1):
  - stop-only command issued;
  - done, status 1;
  - rdata unchanged.
  - With I2C_SEQ_RETRY_EN and RETRIES=2: exactly 3 START attempts before done.
- bc_al asserted during REG:
  - next cycle all bc_* = 0, state IDLE;
  - done with status 2;
  - the late cmd_ack is ignored.
- Back-to-back write then read with req_valid held: second accept occurs on the done cycle, and the first command follows 1 cycle later.
- nReset asserted in RDATA: all outputs 0 immediately; after release, req_ready=1 and a new write completes normally.
